// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core.
//
// Generates the PC enable, the F/D hold and the D/E bubble from three data
// hazard sources (load-use, branch operand, MDU result not ready) and one
// structural source (instruction memory not ready). It also sequences the
// multi-cycle multiply/divide unit with a busy counter and keeps a saturating
// count of cycles in which the PC was held.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   rs_d, rt_d                D-stage source registers
//   use_rs_d, use_rt_d        D instruction actually reads rs / rt
//   is_br_d                   D instruction is a branch resolved in D
//   mdu_use_d                 D instruction reads HI/LO or starts the MDU
//   write_reg_e, reg_write_e  E-stage destination and write enable
//   mem_to_reg_e              E instruction is a load
//   write_reg_m, reg_write_m  M-stage destination and write enable
//   mem_to_reg_m              M instruction is a load
//   mdu_start_e, mdu_is_div_e E instruction starts a multiply / divide
//   imem_ready                instruction memory data valid this cycle
//   pc_en                     PC advance enable
//   stall_d                   hold the F/D register
//   flush_e                   insert a bubble into the D/E register
//   mdu_busy                  MDU operation in progress
//   stall_cycles              saturating count of cycles with pc_en = 0

module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic        use_rs_d,
  input  logic        use_rt_d,
  input  logic        is_br_d,
  input  logic        mdu_use_d,
  input  logic [4:0]  write_reg_e,
  input  logic        reg_write_e,
  input  logic        mem_to_reg_e,
  input  logic [4:0]  write_reg_m,
  input  logic        reg_write_m,
  input  logic        mem_to_reg_m,
  input  logic        mdu_start_e,
  input  logic        mdu_is_div_e,
  input  logic        imem_ready,
  output logic        pc_en,
  output logic        stall_d,
  output logic        flush_e,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles
);

  // The start cycle is busy cycle 1 and the final busy cycle has count 0,
  // so the load value is N-2.
  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 2);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 2);

  typedef enum logic [0:0] {StRun, StMduBusy} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  // ---------------------------------------------------------------------------
  // Register match detection. Register 0 is hard-wired, so it never matches.
  // ---------------------------------------------------------------------------
  logic match_e_rs, match_e_rt, match_m_rs, match_m_rt;
  logic match_e_any, match_m_any;

  always_comb begin
    match_e_rs  = use_rs_d & reg_write_e & (write_reg_e == rs_d) & (rs_d != 5'd0);
    match_e_rt  = use_rt_d & reg_write_e & (write_reg_e == rt_d) & (rt_d != 5'd0);
    match_m_rs  = use_rs_d & reg_write_m & (write_reg_m == rs_d) & (rs_d != 5'd0);
    match_m_rt  = use_rt_d & reg_write_m & (write_reg_m == rt_d) & (rt_d != 5'd0);
    match_e_any = match_e_rs | match_e_rt;
    match_m_any = match_m_rs | match_m_rt;
  end

  // ---------------------------------------------------------------------------
  // Hazard sources
  // ---------------------------------------------------------------------------
  logic lw_stall, br_stall, md_stall, if_stall, data_hz, hz;

  always_comb begin
    lw_stall = mem_to_reg_e & match_e_any;
    // An ALU result in M is forwarded to D elsewhere; only a load in M must wait.
    br_stall = is_br_d & (match_e_any | (mem_to_reg_m & match_m_any));
    md_stall = mdu_use_d & (state_q == StMduBusy);
    if_stall = ~imem_ready;
    data_hz  = lw_stall | br_stall | md_stall;
    hz       = data_hz | if_stall;
  end

  always_comb begin
    pc_en   = ~hz;
    stall_d = hz;
    // On an imem wait D and E both hold, so no bubble is injected then.
    flush_e = data_hz & imem_ready;
  end

  // ---------------------------------------------------------------------------
  // MDU sequencing FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRun;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  // Next state. The counter runs regardless of any pipeline stall.
  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mdu_start_e) begin
          mdu_cnt_d = mdu_is_div_e ? DivLoad : MultLoad;
          state_d   = StMduBusy;
        end
      end
      StMduBusy: begin
        // A start seen here is ignored; its issuer was already held.
        if (mdu_cnt_q == '0) begin
          state_d = StRun;
        end else begin
          mdu_cnt_d = mdu_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d   = StRun;
        mdu_cnt_d = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    mdu_busy = (state_q == StMduBusy);
  end

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Inputs are driven 1 ns after
// the rising edge and outputs are sampled on the falling edge.

module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_d, rt_d;
  logic        use_rs_d, use_rt_d, is_br_d, mdu_use_d;
  logic [4:0]  write_reg_e, write_reg_m;
  logic        reg_write_e, mem_to_reg_e, reg_write_m, mem_to_reg_m;
  logic        mdu_start_e, mdu_is_div_e, imem_ready;
  logic        pc_en, stall_d, flush_e, mdu_busy;
  logic [31:0] stall_cycles;

  int unsigned n_vec;
  int unsigned n_err;

  hazard_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (32),
    .CNT_W      (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .use_rs_d    (use_rs_d),
    .use_rt_d    (use_rt_d),
    .is_br_d     (is_br_d),
    .mdu_use_d   (mdu_use_d),
    .write_reg_e (write_reg_e),
    .reg_write_e (reg_write_e),
    .mem_to_reg_e(mem_to_reg_e),
    .write_reg_m (write_reg_m),
    .reg_write_m (reg_write_m),
    .mem_to_reg_m(mem_to_reg_m),
    .mdu_start_e (mdu_start_e),
    .mdu_is_div_e(mdu_is_div_e),
    .imem_ready  (imem_ready),
    .pc_en       (pc_en),
    .stall_d     (stall_d),
    .flush_e     (flush_e),
    .mdu_busy    (mdu_busy),
    .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs_d = 5'd0; rt_d = 5'd0; use_rs_d = 1'b0; use_rt_d = 1'b0;
    is_br_d = 1'b0; mdu_use_d = 1'b0;
    write_reg_e = 5'd0; reg_write_e = 1'b0; mem_to_reg_e = 1'b0;
    write_reg_m = 5'd0; reg_write_m = 1'b0; mem_to_reg_m = 1'b0;
    mdu_start_e = 1'b0; mdu_is_div_e = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic pe, input logic sd, input logic fe);
    check({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, pe});
    check({tag, ".stall_d"}, {31'd0, stall_d}, {31'd0, sd});
    check({tag, ".flush_e"}, {31'd0, flush_e}, {31'd0, fe});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_ctl("reset", 1'b1, 1'b0, 1'b0);
    check("reset.busy", {31'd0, mdu_busy}, 32'd0);
    check("reset.cnt", stall_cycles, 32'd0);
    rst = 1'b1;

    // Load-use: lw $8 in E, add reading $8 in D
    next_cycle(); idle();
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd8;
    use_rs_d = 1'b1; rs_d = 5'd8;
    @(negedge clk);
    check_ctl("lw_use", 1'b0, 1'b1, 1'b1);
    next_cycle(); idle();
    @(negedge clk);
    check_ctl("lw_bubble", 1'b1, 1'b0, 1'b0);
    check("lw.cnt", stall_cycles, 32'd1);

    // Register zero never hazards
    next_cycle(); idle();
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd0;
    use_rs_d = 1'b1; rs_d = 5'd0;
    @(negedge clk);
    check_ctl("lw_r0", 1'b1, 1'b0, 1'b0);
    next_cycle(); idle();
    is_br_d = 1'b1; use_rt_d = 1'b1; rt_d = 5'd0; reg_write_e = 1'b1; write_reg_e = 5'd0;
    @(negedge clk);
    check_ctl("br_r0", 1'b1, 1'b0, 1'b0);

    // Branch with ALU result in E
    next_cycle(); idle();
    is_br_d = 1'b1; use_rt_d = 1'b1; rt_d = 5'd5; reg_write_e = 1'b1; write_reg_e = 5'd5;
    @(negedge clk);
    check_ctl("br_e", 1'b0, 1'b1, 1'b1);
    next_cycle(); idle();
    @(negedge clk);
    check_ctl("br_e_rel", 1'b1, 1'b0, 1'b0);

    // Branch with load in M, E unrelated
    next_cycle(); idle();
    is_br_d = 1'b1; use_rt_d = 1'b1; rt_d = 5'd5;
    reg_write_e = 1'b1; write_reg_e = 5'd7;
    reg_write_m = 1'b1; mem_to_reg_m = 1'b1; write_reg_m = 5'd5;
    @(negedge clk);
    check_ctl("br_m_lw", 1'b0, 1'b1, 1'b1);

    // Non-branch reading an M load is forwarded, no stall
    next_cycle(); idle();
    use_rt_d = 1'b1; rt_d = 5'd5;
    reg_write_m = 1'b1; mem_to_reg_m = 1'b1; write_reg_m = 5'd5;
    @(negedge clk);
    check_ctl("alu_m_lw", 1'b1, 1'b0, 1'b0);
    check("br.cnt", stall_cycles, 32'd3);

    // Divide started at T; mfhi in D from T+1; a second start at T+10
    next_cycle(); idle();
    mdu_start_e = 1'b1; mdu_is_div_e = 1'b1;
    @(negedge clk);
    check("div.T.busy", {31'd0, mdu_busy}, 32'd0);
    check_ctl("div.T", 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 31; k++) begin
      next_cycle(); idle();
      mdu_use_d = 1'b1;
      if (k == 10) begin
        mdu_start_e = 1'b1; mdu_is_div_e = 1'b1;
      end
      @(negedge clk);
      check($sformatf("div.busy%0d", k), {31'd0, mdu_busy}, 32'd1);
      check($sformatf("div.pc_en%0d", k), {31'd0, pc_en}, 32'd0);
      check($sformatf("div.flush%0d", k), {31'd0, flush_e}, 32'd1);
    end
    next_cycle(); idle();
    mdu_use_d = 1'b1;
    @(negedge clk);
    check("div.T32.busy", {31'd0, mdu_busy}, 32'd0);
    check_ctl("div.T32", 1'b1, 1'b0, 1'b0);
    check("div.cnt", stall_cycles, 32'd34);

    // Imem wait for 3 cycles
    for (int k = 0; k < 3; k++) begin
      next_cycle(); idle();
      imem_ready = 1'b0;
      @(negedge clk);
      check_ctl($sformatf("imem%0d", k), 1'b0, 1'b1, 1'b0);
    end
    next_cycle(); idle();
    @(negedge clk);
    check_ctl("imem_rel", 1'b1, 1'b0, 1'b0);
    check("imem.cnt", stall_cycles, 32'd37);

    // Imem wait combined with load-use: no bubble while imem is not ready
    next_cycle(); idle();
    imem_ready = 1'b0;
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd9;
    use_rt_d = 1'b1; rt_d = 5'd9;
    @(negedge clk);
    check_ctl("imem_lw", 1'b0, 1'b1, 1'b0);
    next_cycle(); idle();
    @(negedge clk);
    check("combo.cnt", stall_cycles, 32'd38);

    // Async reset two cycles after a multiply start
    next_cycle(); idle();
    mdu_start_e = 1'b1;
    @(negedge clk);
    next_cycle(); idle();
    @(negedge clk);
    check("mul.T1.busy", {31'd0, mdu_busy}, 32'd1);
    next_cycle(); idle();
    mdu_use_d = 1'b1;
    #1;
    check("mul.T2.busy", {31'd0, mdu_busy}, 32'd1);
    check("mul.T2.pc_en", {31'd0, pc_en}, 32'd0);
    rst = 1'b0;
    #1;
    check("arst.busy", {31'd0, mdu_busy}, 32'd0);
    check_ctl("arst", 1'b1, 1'b0, 1'b0);
    check("arst.cnt", stall_cycles, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fresh multiply after reset: 4 busy cycles
    next_cycle(); idle();
    mdu_start_e = 1'b1;
    @(negedge clk);
    check("mul2.T.busy", {31'd0, mdu_busy}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      next_cycle(); idle();
      @(negedge clk);
      check($sformatf("mul2.busy%0d", k), {31'd0, mdu_busy}, 32'd1);
    end
    next_cycle(); idle();
    @(negedge clk);
    check("mul2.T5.busy", {31'd0, mdu_busy}, 32'd0);
    check("mul2.cnt", stall_cycles, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
